ps2_host_port: RTL and testbench
================================

Name: ps2_host_port

Overview:
- Host-side PS/2 port that sits directly downstream of the PS/2 keyboard/mouse device emulator and consumes its open-collector clock/data lines.
- Deserialises device-to-host frames into a small first-word-fall-through RX FIFO for the 8042 controller model.
- Serialises host-to-device command bytes using the standard inhibit / request-to-send / ack sequence.
- Applies host flow control by inhibiting the clock while the RX FIFO is full.

Parameters:
- FIFO_BITS, 2, log2 of RX FIFO depth (4 entries).
- INHIBIT_CYCLES, 1200, clk_sys cycles the host holds clock low before a TX start bit.
- TIMEOUT_CYCLES, 30000, maximum clk_sys cycles between clock falling edges inside a frame before abort.

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- ps2_clk_in  in  1  wired PS/2 clock line (device drive AND host drive).
- ps2_dat_in  in  1  wired PS/2 data line.
- ps2_clk_out  out  1  host clock drive; 1 = released, 0 = pulled low.
- ps2_dat_out  out  1  host data drive; 1 = released, 0 = pulled low.
- tx_data  in  8  command byte to send.
- tx_we  in  1  write strobe; accepted only when tx_busy=0.
- tx_busy  out  1  a TX byte is pending or in progress.
- tx_done  out  1  one-cycle pulse: device acked the byte.
- tx_err  out  1  one-cycle pulse: no ack, or timeout during TX.
- rx_data  out  8  FIFO head byte (valid when rx_valid=1).
- rx_valid  out  1  FIFO not empty.
- rx_rd  in  1  pops the head; ignored when empty.
- rx_err  out  1  one-cycle pulse: parity, stop-bit or timeout error on RX.
- rx_overflow  out  1  sticky: a good frame was dropped because the FIFO was full.
- rx_ovf_clr  in  1  clears rx_overflow.

Behaviour:
- Reset values: ps2_clk_out=1, ps2_dat_out=1, FIFO empty (rx_valid=0), tx_busy=0, all pulses 0, rx_overflow=0, state=IDLE. Reset mid-frame aborts the frame immediately.
- Inputs pass through a 2-FF synchroniser. "fall" means the synchronised clock was 1 last cycle and is 0 now. All decisions use the synchronised values.
- States: IDLE, RX, TX_INH, TX_BITS, TX_ACK.
- IDLE:
  - fall with data=0 -> RX, bit_cnt=0. This takes priority over a pending TX.
  - Otherwise, if a TX is pending -> TX_INH, counter cleared.
  - Otherwise, if the FIFO is full, ps2_clk_out=0 (inhibit); else ps2_clk_out=1.
- RX: each fall samples the data line.
  - bit_cnt 0-7: data bits, LSB first.
  - bit_cnt 8: parity bit.
  - bit_cnt 9: stop bit; return to IDLE on this bit.
  - Good frame = odd parity over data+parity AND stop=1.
  - Good frame with FIFO not full (or rx_rd popping a non-empty FIFO in the same cycle): push; rx_valid rises the next cycle.
  - Good frame with FIFO full and no pop: byte dropped, rx_overflow=1.
  - Bad frame: rx_err pulse, no push.
- TX:
  - tx_we with tx_busy=0 latches tx_data and sets tx_busy the next cycle, even if an RX frame is in progress. The TX starts after that frame.
  - tx_we while tx_busy=1 is ignored.
  - TX_INH: ps2_clk_out=0 for INHIBIT_CYCLES. On the final cycle, set ps2_dat_out=0 (start bit) and ps2_clk_out=1, then enter TX_BITS with bit_cnt=0.
  - TX_BITS: each fall drives the next bit onto ps2_dat_out: data0..data7, then odd parity, then stop=1. On the fall after the stop bit is driven, release ps2_dat_out=1 and enter TX_ACK.
  - TX_ACK: next fall samples data. 0 -> tx_done pulse. 1 -> tx_err pulse. Either way tx_busy=0 the following cycle and state returns to IDLE.
- Timeout: the counter resets on every fall and counts only in RX, TX_BITS and TX_ACK. Reaching TIMEOUT_CYCLES -> release both lines, go to IDLE, and pulse rx_err (if in RX) or tx_err (if in a TX state). A TX timeout clears tx_busy.
- FIFO:
  - Pointers have FIFO_BITS+1 bits for full/empty detection and wrap naturally.
  - rx_data is combinational from the head entry.
  - Pop and push in the same cycle on a non-empty FIFO keeps the count unchanged.
- rx_ovf_clr in the same cycle as a new overflow: the overflow wins (flag stays 1).

Test Plan:
- Device sends 0x1C, parity bit 0, stop bit 1 -> rx_valid=1, rx_data=0x1C, no rx_err. rx_rd -> rx_valid=0.
- Device sends 0xAA with parity bit 0 (bad) -> rx_err pulse, FIFO stays empty.
- Device sends 5 good bytes 0x01..0x05 with no reads -> FIFO holds 0x01..0x04, rx_overflow=1, ps2_clk_out=0 while full. Pop one -> clock released. rx_ovf_clr -> rx_overflow=0.
- tx_we with 0xFF, device clocks the frame and pulls data low on the ack fall -> ps2_clk_out low for 1200 cycles, bits 1,1,1,1,1,1,1,1, parity 1, stop 1, tx_done pulse, tx_busy=0.
- tx_we with 0xED, device stops clocking after 3 bits -> tx_err after 30000 cycles, both lines released, tx_busy=0.
- tx_we in the same cycle as a device start-bit fall -> RX frame completes first, then TX_INH begins; assert reset mid-TX -> all outputs return to reset values the next cycle.

Source files
------------

// File: rtl/ps2_host_port.sv
// Host side of a PS/2 link: receives device frames into a small FWFT FIFO,
// sends command bytes with the inhibit / request-to-send / ack sequence, and
// inhibits the clock while the FIFO is full.
//
// Handshakes:
//   tx_we/tx_busy: a byte is taken on any cycle with tx_we=1 and tx_busy=0.
//     tx_busy rises the next cycle and stays high until tx_done or tx_err.
//   rx_valid/rx_rd: rx_data is valid whenever rx_valid=1. A cycle with
//     rx_valid=1 and rx_rd=1 consumes the head. rx_rd with rx_valid=0 is ignored.
module ps2_host_port #(
  parameter int FIFO_BITS      = 2,
  parameter int INHIBIT_CYCLES = 1200,
  parameter int TIMEOUT_CYCLES = 30000
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_out,
  output logic       ps2_dat_out,
  input  logic [7:0] tx_data,
  input  logic       tx_we,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_rd,
  output logic       rx_err,
  output logic       rx_overflow,
  input  logic       rx_ovf_clr,
  output logic [2:0] dbg_state
);

  localparam int DEPTH   = 1 << FIFO_BITS;
  localparam int CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [FIFO_BITS:0] PTR_ONE = 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RX      = 3'd1,
    TX_INH  = 3'd2,
    TX_BITS = 3'd3,
    TX_ACK  = 3'd4
  } state_e;

  state_e        state_q;
  logic          clk_s1_q, clk_s2_q, clk_prev_q, dat_s1_q, dat_s2_q;
  logic [CW-1:0] cnt_q;
  logic [3:0]    bit_cnt_q;
  logic [7:0]    rx_shift_q;
  logic          rx_par_q;
  logic [7:0]    tx_byte_q;
  logic          tx_busy_q, tx_done_q, tx_err_q, rx_err_q;
  logic          clk_out_q, dat_out_q;
  logic          ovf_q;

  logic [7:0]       mem_q [DEPTH];
  logic [FIFO_BITS:0] wr_ptr_q, rd_ptr_q;

  logic fall, empty, full, pop, frame_end, frame_good, push, ovf_set, timeout;

  assign fall       = clk_prev_q & ~clk_s2_q;
  assign empty      = (wr_ptr_q == rd_ptr_q);
  assign full       = (wr_ptr_q[FIFO_BITS] != rd_ptr_q[FIFO_BITS]) &&
                      (wr_ptr_q[FIFO_BITS-1:0] == rd_ptr_q[FIFO_BITS-1:0]);
  assign pop        = rx_rd & ~empty;
  assign frame_end  = (state_q == RX) && fall && (bit_cnt_q == 4'd9);
  // Odd parity over data+parity and a high stop bit make a good frame.
  assign frame_good = frame_end && dat_s2_q && (^{rx_shift_q, rx_par_q});
  assign push       = frame_good && (!full || pop);
  assign ovf_set    = frame_good && full && !pop;
  assign timeout    = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  // Two-flop synchronisers; an extra clock stage gives the fall detector.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
    end else begin
      clk_s1_q   <= ps2_clk_in;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      dat_s1_q   <= ps2_dat_in;
      dat_s2_q   <= dat_s1_q;
    end
  end

  // FIFO storage; contents need no reset because the pointers gate them.
  always_ff @(posedge clk_sys) begin
    if (push) mem_q[wr_ptr_q[FIFO_BITS-1:0]] <= rx_shift_q;
  end

  // FIFO pointers, one bit wider than the index so full and empty differ.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  // Sticky overflow flag; a new overflow beats a same-cycle clear.
  always_ff @(posedge clk_sys) begin
    if (reset)           ovf_q <= 1'b0;
    else if (ovf_set)    ovf_q <= 1'b1;
    else if (rx_ovf_clr) ovf_q <= 1'b0;
  end

  // Link state machine: RX deserialiser, TX sequencer, timeouts and line drives.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_cnt_q  <= '0;
      rx_shift_q <= '0;
      rx_par_q   <= 1'b0;
      tx_byte_q  <= '0;
      tx_busy_q  <= 1'b0;
      tx_done_q  <= 1'b0;
      tx_err_q   <= 1'b0;
      rx_err_q   <= 1'b0;
      clk_out_q  <= 1'b1;
      dat_out_q  <= 1'b1;
    end else begin
      tx_done_q <= 1'b0;
      tx_err_q  <= 1'b0;
      rx_err_q  <= 1'b0;
      if (tx_we && !tx_busy_q) begin
        tx_busy_q <= 1'b1;
        tx_byte_q <= tx_data;
      end
      case (state_q)
        IDLE: begin
          cnt_q     <= '0;
          dat_out_q <= 1'b1;
          if (fall && !dat_s2_q) begin
            // A device start bit wins over a pending command.
            state_q   <= RX;
            bit_cnt_q <= '0;
            clk_out_q <= 1'b1;
          end else if (tx_busy_q) begin
            state_q   <= TX_INH;
            clk_out_q <= 1'b0;
          end else begin
            clk_out_q <= ~full;
          end
        end
        RX: begin
          if (fall) begin
            cnt_q     <= '0;
            bit_cnt_q <= bit_cnt_q + 4'd1;
            if (bit_cnt_q < 4'd8) rx_shift_q <= {dat_s2_q, rx_shift_q[7:1]};
            else if (bit_cnt_q == 4'd8) rx_par_q <= dat_s2_q;
            else begin
              state_q <= IDLE;
              if (!frame_good) rx_err_q <= 1'b1;
            end
          end else if (timeout) begin
            state_q   <= IDLE;
            clk_out_q <= 1'b1;
            dat_out_q <= 1'b1;
            rx_err_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        TX_INH: begin
          if (cnt_q == CW'(INHIBIT_CYCLES - 1)) begin
            // Request-to-send: start bit low, then hand the clock to the device.
            state_q   <= TX_BITS;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            clk_out_q <= 1'b1;
            dat_out_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        TX_BITS: begin
          if (fall) begin
            cnt_q     <= '0;
            bit_cnt_q <= bit_cnt_q + 4'd1;
            if (bit_cnt_q < 4'd8)       dat_out_q <= tx_byte_q[bit_cnt_q[2:0]];
            else if (bit_cnt_q == 4'd8) dat_out_q <= ~^tx_byte_q;
            else if (bit_cnt_q == 4'd9) dat_out_q <= 1'b1;
            else begin
              dat_out_q <= 1'b1;
              state_q   <= TX_ACK;
            end
          end else if (timeout) begin
            state_q   <= IDLE;
            clk_out_q <= 1'b1;
            dat_out_q <= 1'b1;
            tx_err_q  <= 1'b1;
            tx_busy_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        TX_ACK: begin
          if (fall) begin
            cnt_q     <= '0;
            state_q   <= IDLE;
            tx_busy_q <= 1'b0;
            if (!dat_s2_q) tx_done_q <= 1'b1;
            else           tx_err_q  <= 1'b1;
          end else if (timeout) begin
            state_q   <= IDLE;
            clk_out_q <= 1'b1;
            dat_out_q <= 1'b1;
            tx_err_q  <= 1'b1;
            tx_busy_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ps2_clk_out = clk_out_q;
  assign ps2_dat_out = dat_out_q;
  assign tx_busy     = tx_busy_q;
  assign tx_done     = tx_done_q;
  assign tx_err      = tx_err_q;
  assign rx_err      = rx_err_q;
  assign rx_overflow = ovf_q;
  assign rx_valid    = ~empty;
  assign rx_data     = mem_q[rd_ptr_q[FIFO_BITS-1:0]];
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_ps2_host_port.sv
// Directed + randomized bench for ps2_host_port with a behavioural device
// on the wired-AND PS/2 lines and a queue model of the RX FIFO.
`timescale 1ns/1ps
module tb_ps2_host_port;

  localparam int HALF = 20;   // clk_sys cycles per PS/2 half period
  localparam int DEPTH = 4;
  localparam int INH = 1200;
  localparam int TO = 30000;

  // ---------------- clock / reset ----------------
  logic clk_sys = 1'b0;
  logic reset = 1'b1;
  always #5 clk_sys = ~clk_sys;

  logic dev_clk = 1'b1, dev_dat = 1'b1, honor = 1'b1;
  logic ps2_clk_in, ps2_dat_in, ps2_clk_out, ps2_dat_out;
  logic [7:0] tx_data = '0;
  logic tx_we = 1'b0, rx_rd = 1'b0, rx_ovf_clr = 1'b0;
  logic tx_busy, tx_done, tx_err, rx_valid, rx_err, rx_overflow;
  logic [7:0] rx_data;
  logic [2:0] dbg_state;

  // Wired-AND lines; honor=0 models a device that keeps clocking through an inhibit.
  assign ps2_clk_in = dev_clk & (ps2_clk_out | ~honor);
  assign ps2_dat_in = dev_dat & ps2_dat_out;

  ps2_host_port dut (
    .clk_sys(clk_sys), .reset(reset),
    .ps2_clk_in(ps2_clk_in), .ps2_dat_in(ps2_dat_in),
    .ps2_clk_out(ps2_clk_out), .ps2_dat_out(ps2_dat_out),
    .tx_data(tx_data), .tx_we(tx_we), .tx_busy(tx_busy),
    .tx_done(tx_done), .tx_err(tx_err),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_rd(rx_rd),
    .rx_err(rx_err), .rx_overflow(rx_overflow), .rx_ovf_clr(rx_ovf_clr),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  int rx_err_n = 0, tx_done_n = 0, tx_err_n = 0;
  int exp_rx_err = 0;
  logic exp_ovf = 1'b0;

  always @(negedge clk_sys) begin
    if (!reset) begin
      if (rx_err)  rx_err_n++;
      if (tx_done) tx_done_n++;
      if (tx_err)  tx_err_n++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference frame rule: good when data+parity has odd weight and stop is high.
  function automatic bit frame_ok(input logic [7:0] d, input logic p, input logic s);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += d[i];
    ones += p;
    return (ones % 2 == 1) && s;
  endfunction

  function automatic logic odd_par(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += d[i];
    return (ones % 2 == 0);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  // Device-to-host frame; optionally strobes tx_we as the host sees the start fall.
  task automatic dev_frame(input logic [7:0] d, input logic p, input logic s,
                           input bit tx_at_start, input logic [7:0] txd);
    logic [10:0] bits;
    bits = {s, p, d, 1'b0};
    for (int k = 0; k < 11; k++) begin
      dev_dat = bits[k];
      wait_cycles(HALF);
      dev_clk = 1'b0;
      if (k == 0 && tx_at_start) begin
        wait_cycles(2);
        tx_data = txd;
        tx_we = 1'b1;
        @(negedge clk_sys);
        tx_we = 1'b0;
        wait_cycles(HALF - 3);
      end else begin
        wait_cycles(HALF);
      end
      dev_clk = 1'b1;
    end
    dev_dat = 1'b1;
    wait_cycles(HALF);
  endtask

  // Model update for one device frame sent with no pops in flight.
  task automatic model_frame(input logic [7:0] d, input logic p, input logic s);
    if (!frame_ok(d, p, s)) exp_rx_err++;
    else if (exp_q.size() < DEPTH) exp_q.push_back(d);
    else exp_ovf = 1'b1;
  endtask

  task automatic send_rx(input logic [7:0] d, input logic p, input logic s);
    dev_frame(d, p, s, 1'b0, 8'h00);
    model_frame(d, p, s);
  endtask

  task automatic do_pop(input string tag);
    logic [7:0] e;
    e = exp_q.pop_front();
    check({tag, "_valid"}, rx_valid, 1);
    check({tag, "_data"}, rx_data, e);
    rx_rd = 1'b1;
    @(negedge clk_sys);
    rx_rd = 1'b0;
  endtask

  // Host-to-device command; device clocks nf falls and acks low when ack_low.
  task automatic tx_byte(input logic [7:0] d, input int nf, input bit ack_low,
                         output int inh_cycles, output logic [9:0] seen);
    int t;
    seen = '0;
    @(negedge clk_sys);
    tx_data = d;
    tx_we = 1'b1;
    @(negedge clk_sys);
    tx_we = 1'b0;
    check("tx_busy_set", tx_busy, 1);
    t = 0;
    while (ps2_clk_out !== 1'b0 && t < 50) begin @(negedge clk_sys); t++; end
    check("tx_inh_start", ps2_clk_out, 0);
    inh_cycles = 0;
    while (ps2_clk_out === 1'b0 && inh_cycles < 3000) begin
      inh_cycles++;
      @(negedge clk_sys);
    end
    check("tx_start_bit", ps2_dat_out, 0);
    for (int k = 1; k <= nf; k++) begin
      if (k == 12 && ack_low) dev_dat = 1'b0;
      wait_cycles(HALF);
      dev_clk = 1'b0;
      wait_cycles(HALF);
      dev_clk = 1'b1;
      if (k <= 10) seen[k-1] = ps2_dat_out;
    end
    dev_dat = 1'b1;
    wait_cycles(5);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int inh, e0, t, npop;
    logic [9:0] seen;
    logic [7:0] d;
    logic p;

    wait_cycles(5);
    // Reset state
    check("rst_clk_out", ps2_clk_out, 1);
    check("rst_dat_out", ps2_dat_out, 1);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_tx_busy", tx_busy, 0);
    check("rst_pulses", {tx_done, tx_err, rx_err}, 0);
    check("rst_ovf", rx_overflow, 0);
    check("rst_state", dbg_state, 0);
    reset = 1'b0;
    wait_cycles(5);

    // One good byte
    send_rx(8'h1C, 1'b0, 1'b1);
    check("rx1c_err", rx_err_n, exp_rx_err);
    do_pop("rx1c");
    wait_cycles(2);
    check("rx1c_empty", rx_valid, 0);

    // Bad parity
    send_rx(8'hAA, 1'b0, 1'b1);
    check("rxaa_err", rx_err_n, exp_rx_err);
    check("rxaa_empty", rx_valid, 0);

    // Fill the FIFO, then overflow with a device that ignores the inhibit
    for (int i = 1; i <= 4; i++) send_rx(8'(i), odd_par(8'(i)), 1'b1);
    check("full_inhibit", ps2_clk_out, 0);
    check("full_no_ovf", rx_overflow, 0);
    honor = 1'b0;
    send_rx(8'h05, odd_par(8'h05), 1'b1);
    honor = 1'b1;
    check("ovf_set", rx_overflow, exp_ovf);
    check("ovf_inhibit", ps2_clk_out, 0);
    check("ovf_no_err", rx_err_n, exp_rx_err);
    do_pop("ovf_pop");
    wait_cycles(3);
    check("release_after_pop", ps2_clk_out, 1);
    rx_ovf_clr = 1'b1;
    @(negedge clk_sys);
    rx_ovf_clr = 1'b0;
    check("ovf_clr", rx_overflow, 0);
    while (exp_q.size() > 0) do_pop("drain");
    wait_cycles(2);
    check("drain_empty", rx_valid, 0);

    // Randomized RX traffic with random pops
    for (int i = 0; i < 10; i++) begin
      d = 8'($urandom_range(0, 255));
      p = odd_par(d) ^ ($urandom_range(0, 3) == 0);
      send_rx(d, p, 1'b1);
      check("rnd_err", rx_err_n, exp_rx_err);
      check("rnd_valid", rx_valid, exp_q.size() > 0);
      npop = $urandom_range(0, exp_q.size());
      if (exp_q.size() == DEPTH && npop == 0) npop = 1;
      for (int j = 0; j < npop; j++) do_pop("rnd_pop");
      wait_cycles(2);
    end
    while (exp_q.size() > 0) do_pop("rnd_drain");
    wait_cycles(3);

    // TX 0xFF with ack, then a random byte with ack
    for (int i = 0; i < 2; i++) begin
      d = (i == 0) ? 8'hFF : 8'($urandom_range(0, 255));
      e0 = tx_done_n;
      tx_byte(d, 12, 1'b1, inh, seen);
      check("tx_inh_len", inh, INH);
      check("tx_bits", seen, {1'b1, odd_par(d), d});
      check("tx_done", tx_done_n - e0, 1);
      check("tx_busy_clr", tx_busy, 0);
      check("tx_dat_rel", ps2_dat_out, 1);
    end
    check("tx_no_err", tx_err_n, 0);

    // TX 0xED, device stops after 3 bits -> timeout
    e0 = tx_err_n;
    tx_byte(8'hED, 3, 1'b0, inh, seen);
    t = 0;
    while (tx_err_n == e0 && t < TO + 1000) begin @(negedge clk_sys); t++; end
    check("tx_timeout_err", tx_err_n - e0, 1);
    check("tx_timeout_clk", ps2_clk_out, 1);
    check("tx_timeout_dat", ps2_dat_out, 1);
    check("tx_timeout_busy", tx_busy, 0);

    // tx_we alongside a device start bit: RX completes first, then inhibit
    d = 8'($urandom_range(0, 255));
    dev_frame(d, odd_par(d), 1'b1, 1'b1, 8'h5A);
    model_frame(d, odd_par(d), 1'b1);
    check("race_rx_valid", rx_valid, 1);
    check("race_rx_data", rx_data, exp_q[0]);
    check("race_tx_busy", tx_busy, 1);
    t = 0;
    while (ps2_clk_out !== 1'b0 && t < 50) begin @(negedge clk_sys); t++; end
    check("race_inh", ps2_clk_out, 0);
    wait_cycles(100);
    reset = 1'b1;
    @(negedge clk_sys);
    exp_q.delete();
    check("midtx_clk", ps2_clk_out, 1);
    check("midtx_dat", ps2_dat_out, 1);
    check("midtx_busy", tx_busy, 0);
    check("midtx_valid", rx_valid, 0);
    check("midtx_pulses", {tx_done, tx_err, rx_err, rx_overflow}, 0);
    check("midtx_state", dbg_state, 0);
    reset = 1'b0;
    wait_cycles(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
